sram_port_arbiter: RTL

Two-requester arbiter that multiplexes the CPU control path and the DMA engine onto the single-port SRAM. It owns the SRAM port signals, grants one transaction per cycle, and returns read data to the requester that issued the read. CPU has priority, and a starvation guard guarantees DMA progress. It sits between the CPU core, the DMA engine and the SRAM instance inside the SP top level.

---
 rtl/sram_port_arbiter_pkg.sv | 22 ++
 rtl/sram_rd_tag_pipe.sv | 25 ++
 rtl/sram_port_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: policy FSM states and read-return tags.
package sram_port_arbiter_pkg;

  typedef enum logic [0:0] {
    ArbCpuPri  = 1'b0,
    ArbDmaTurn = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OwnerCpu = 1'b0,
    OwnerDma = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

  localparam int unsigned ContendW = 16;
  localparam int unsigned StreakW  = 16;

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Two-stage {valid, owner} shift register that follows each granted read to its data beat.
module sram_rd_tag_pipe
  import sram_port_arbiter_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage1_q, stage2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= tag_i;
      stage2_q <= stage1_q;
    end
  end

  assign tag_o = stage2_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// CPU/DMA arbiter for a single-port SRAM: CPU priority with a starvation guard for DMA,
// registered SRAM pins, and read data steered back to the requester that issued the read.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cpu_req_i,
  input  logic                cpu_we_i,
  input  logic [AW-1:0]       cpu_addr_i,
  input  logic [DW-1:0]       cpu_di_i,
  input  logic                dma_req_i,
  input  logic                dma_we_i,
  input  logic [AW-1:0]       dma_addr_i,
  input  logic [DW-1:0]       dma_di_i,
  input  logic                dma_block_i,
  output logic                cpu_gnt_o,
  output logic                dma_gnt_o,
  output logic                cpu_rvalid_o,
  output logic                dma_rvalid_o,
  output logic [DW-1:0]       cpu_do_o,
  output logic [DW-1:0]       dma_do_o,
  output logic [AW-1:0]       sram_addr_o,
  output logic [DW-1:0]       sram_di_o,
  output logic                sram_en_o,
  output logic                sram_we_o,
  input  logic [DW-1:0]       sram_do_i,
  output logic [ContendW-1:0] contend_cnt_o
);

  localparam logic [StreakW-1:0] Limit = StreakW'(StarveLimit);

  arb_state_e         state_q, state_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic               cpu_elig, dma_elig, contested, any_gnt, win_we;

  assign cpu_elig  = cpu_req_i;
  assign dma_elig  = dma_req_i & ~dma_block_i;
  assign contested = cpu_elig & dma_elig;

  // Policy state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ArbCpuPri;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  // Policy next state
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      ArbCpuPri: begin
        if (!contested || (StarveLimit == 0)) begin
          streak_d = '0;
        end else if (streak_q + StreakW'(1) == Limit) begin
          state_d  = ArbDmaTurn;
          streak_d = '0;
        end else begin
          streak_d = streak_q + StreakW'(1);
        end
      end
      ArbDmaTurn: begin
        // Blocked DMA cannot be granted, so the turn is held until it is.
        if (dma_gnt_o) state_d = ArbCpuPri;
      end
      default: state_d = ArbCpuPri;
    endcase
  end

  // Grant outputs; forced low while reset is asserted
  always_comb begin
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    if (rst_ni) begin
      if (contested) begin
        if (state_q == ArbDmaTurn) dma_gnt_o = 1'b1;
        else                       cpu_gnt_o = 1'b1;
      end else if (cpu_elig) begin
        cpu_gnt_o = 1'b1;
      end else if (dma_elig) begin
        dma_gnt_o = 1'b1;
      end
    end
  end

  assign any_gnt = cpu_gnt_o | dma_gnt_o;
  assign win_we  = cpu_gnt_o ? cpu_we_i : dma_we_i;

  logic [AW-1:0] addr_q;
  logic [DW-1:0] di_q;
  logic          en_q, we_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      di_q   <= '0;
      en_q   <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      en_q <= any_gnt;
      we_q <= any_gnt & win_we;
      if (any_gnt) begin
        addr_q <= cpu_gnt_o ? cpu_addr_i : dma_addr_i;
        di_q   <= cpu_gnt_o ? cpu_di_i : dma_di_i;
      end
    end
  end

  assign sram_addr_o = addr_q;
  assign sram_di_o   = di_q;
  assign sram_en_o   = en_q;
  assign sram_we_o   = we_q;

  rd_tag_t push_tag, ret_tag;

  assign push_tag.valid = any_gnt & ~win_we;
  assign push_tag.owner = dma_gnt_o ? OwnerDma : OwnerCpu;

  sram_rd_tag_pipe u_tag_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tag_i  (push_tag),
    .tag_o  (ret_tag)
  );

  assign cpu_rvalid_o = ret_tag.valid & (ret_tag.owner == OwnerCpu);
  assign dma_rvalid_o = ret_tag.valid & (ret_tag.owner == OwnerDma);
  assign cpu_do_o     = cpu_rvalid_o ? sram_do_i : '0;
  assign dma_do_o     = dma_rvalid_o ? sram_do_i : '0;

  logic [ContendW-1:0] contend_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      contend_q <= '0;
    end else if (dma_req_i && !dma_gnt_o && (contend_q != '1)) begin
      contend_q <= contend_q + ContendW'(1);
    end
  end

  assign contend_cnt_o = contend_q;

endmodule
